// File: rtl/sargantana_itag_memory_flush_if.sv
// ---------------------------------------------------------------------------
// sargantana_itag_memory_flush_if
//   Bus between the icache controller (master) and the instruction-cache
//   tag/valid store (slave).
//
//   Controller -> tag store:
//     req_i      per-way access enable
//     we_i       1 = write the selected ways, 0 = read
//     vbit_i     valid bit to write
//     flush_i    start / restart invalidate-all
//     data_i     tag to write
//     addr_i     set index
//     cmp_tag_i  lookup tag, sampled with a read
//   Tag store -> controller:
//     tag_way_o     registered tag per way
//     vbit_o        registered valid per way
//     hit_way_o     per-way hit
//     hit_o         any way hit
//     multi_hit_o   more than one way hit
//     flush_busy_o  flush engine active
//     parity_err_o  per-way tag parity error
// ---------------------------------------------------------------------------
interface sargantana_itag_memory_flush_if #(
    parameter int unsigned ICACHE_N_WAY   = 4,
    parameter int unsigned TAG_WIDHT      = 20,
    parameter int unsigned TAG_ADDR_WIDHT = 6
);
    logic [ICACHE_N_WAY-1:0]                req_i;
    logic                                   we_i;
    logic                                   vbit_i;
    logic                                   flush_i;
    logic [TAG_WIDHT-1:0]                   data_i;
    logic [TAG_ADDR_WIDHT-1:0]              addr_i;
    logic [TAG_WIDHT-1:0]                   cmp_tag_i;
    logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tag_way_o;
    logic [ICACHE_N_WAY-1:0]                vbit_o;
    logic [ICACHE_N_WAY-1:0]                hit_way_o;
    logic                                   hit_o;
    logic                                   multi_hit_o;
    logic                                   flush_busy_o;
    logic [ICACHE_N_WAY-1:0]                parity_err_o;

    modport master (
        output req_i, we_i, vbit_i, flush_i, data_i, addr_i, cmp_tag_i,
        input  tag_way_o, vbit_o, hit_way_o, hit_o, multi_hit_o,
               flush_busy_o, parity_err_o
    );

    modport slave (
        input  req_i, we_i, vbit_i, flush_i, data_i, addr_i, cmp_tag_i,
        output tag_way_o, vbit_o, hit_way_o, hit_o, multi_hit_o,
               flush_busy_o, parity_err_o
    );
endinterface

// File: rtl/sargantana_itag_memory_flush.sv
// ---------------------------------------------------------------------------
// sargantana_itag_memory_flush
//   L1 instruction-cache tag/valid store: ICACHE_N_WAY ways of
//   TAG_DEPTH x TAG_WIDHT tags plus per-way valid bits, with a registered
//   tag compare (per-way hit vector, multi-hit flag).
//   Valid bits live in a non-resettable array; a set-walking flush engine
//   clears them one set per cycle after reset and on flush_i.
//
//   Ports:
//     clk_i   clock
//     rstn_i  synchronous active-low reset
//     bus     sargantana_itag_memory_flush_if.slave (request / result bus)
//
//   Optional feature (macro ITAG_PARITY_EN):
//     each tag entry carries an even-parity bit; a read with a parity
//     mismatch raises parity_err_o for that way and forces its vbit_o to 0.
//     Without the macro parity_err_o is tied to 0.
// ---------------------------------------------------------------------------
module sargantana_itag_memory_flush #(
    parameter int unsigned ICACHE_N_WAY   = 4,
    parameter int unsigned TAG_DEPTH      = 64,
    parameter int unsigned TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
    parameter int unsigned TAG_WIDHT      = 20
) (
    input logic                        clk_i,
    input logic                        rstn_i,
    sargantana_itag_memory_flush_if.slave bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [TAG_ADDR_WIDHT-1:0] LAST_SET = TAG_ADDR_WIDHT'(TAG_DEPTH - 1);

`ifdef ITAG_PARITY_EN
    localparam int unsigned ENTRY_W = TAG_WIDHT + 1;
`else
    localparam int unsigned ENTRY_W = TAG_WIDHT;
`endif

    // Storage arrays (deliberately not reset).
    logic [ENTRY_W-1:0]   tag_mem   [ICACHE_N_WAY][TAG_DEPTH];
    logic [TAG_DEPTH-1:0] valid_mem [ICACHE_N_WAY];

    logic [0:0]                             state_q;
    logic [TAG_ADDR_WIDHT-1:0]              counter_q;
    logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tag_q;
    logic [ICACHE_N_WAY-1:0]                vbit_q;
    logic [TAG_WIDHT-1:0]                   cmp_tag_q;
    logic [ICACHE_N_WAY-1:0]                hit_way;
    logic [ENTRY_W-1:0]                     wr_entry;
    logic                                   do_write;
    logic                                   do_read;

    // A flush request in IDLE wins over any access in the same cycle.
    assign do_write = (state_q == IDLE) && !bus.flush_i && bus.we_i;
    assign do_read  = (state_q == IDLE) && !bus.flush_i && !bus.we_i && (|bus.req_i);

`ifdef ITAG_PARITY_EN
    logic [ICACHE_N_WAY-1:0] perr_q;
    // Stored parity bit makes the XOR of the whole entry zero.
    assign wr_entry = {^bus.data_i, bus.data_i};
`else
    assign wr_entry = bus.data_i;
`endif

    // Array write port: flush clears one set per cycle, otherwise normal writes.
    always_ff @(posedge clk_i) begin
        if (rstn_i) begin
            if (state_q == FLUSH) begin
                for (int unsigned w = 0; w < ICACHE_N_WAY; w++) begin
                    valid_mem[w][counter_q] <= 1'b0;
                end
            end else if (do_write) begin
                for (int unsigned w = 0; w < ICACHE_N_WAY; w++) begin
                    if (bus.req_i[w]) begin
                        tag_mem[w][bus.addr_i]   <= wr_entry;
                        valid_mem[w][bus.addr_i] <= bus.vbit_i;
                    end
                end
            end
        end
    end

    // Control FSM and registered read outputs.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q   <= FLUSH;
            counter_q <= '0;
            tag_q     <= '0;
            vbit_q    <= '0;
            cmp_tag_q <= '0;
`ifdef ITAG_PARITY_EN
            perr_q    <= '0;
`endif
        end else begin
            case (state_q)
                FLUSH: begin
                    vbit_q <= '0;
                    if (bus.flush_i) begin
                        counter_q <= '0;
                    end else begin
                        if (counter_q == LAST_SET) begin
                            state_q <= IDLE;
                        end
                        counter_q <= counter_q + TAG_ADDR_WIDHT'(1);
                    end
                end
                default: begin
                    if (bus.flush_i) begin
                        state_q   <= FLUSH;
                        counter_q <= '0;
                    end else if (do_read) begin
                        cmp_tag_q <= bus.cmp_tag_i;
`ifdef ITAG_PARITY_EN
                        perr_q <= '0;
`endif
                        for (int unsigned w = 0; w < ICACHE_N_WAY; w++) begin
                            if (bus.req_i[w]) begin
                                tag_q[w] <= tag_mem[w][bus.addr_i][TAG_WIDHT-1:0];
`ifdef ITAG_PARITY_EN
                                perr_q[w] <= ^tag_mem[w][bus.addr_i];
                                vbit_q[w] <= valid_mem[w][bus.addr_i] & ~(^tag_mem[w][bus.addr_i]);
`else
                                vbit_q[w] <= valid_mem[w][bus.addr_i];
`endif
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        hit_way = '0;
        for (int unsigned w = 0; w < ICACHE_N_WAY; w++) begin
            hit_way[w] = vbit_q[w] & (tag_q[w] == cmp_tag_q);
        end
    end

    assign bus.tag_way_o    = tag_q;
    assign bus.vbit_o       = vbit_q;
    assign bus.hit_way_o    = hit_way;
    assign bus.hit_o        = |hit_way;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign bus.multi_hit_o  = |(hit_way & (hit_way - ICACHE_N_WAY'(1)));
    assign bus.flush_busy_o = (state_q == FLUSH);
`ifdef ITAG_PARITY_EN
    assign bus.parity_err_o = perr_q;
`else
    assign bus.parity_err_o = '0;
`endif

endmodule

// File: tb/tb_sargantana_itag_memory_flush.sv
// ---------------------------------------------------------------------------
// tb_sargantana_itag_memory_flush
//   Directed self-checking bench for sargantana_itag_memory_flush with the
//   default geometry (4 ways, 64 sets, 20-bit tags). Inputs change and
//   outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_sargantana_itag_memory_flush;

    localparam int unsigned NW = 4;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW = 6;
    localparam int unsigned TW = 20;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    sargantana_itag_memory_flush_if #(
        .ICACHE_N_WAY   (NW),
        .TAG_WIDHT      (TW),
        .TAG_ADDR_WIDHT (AW)
    ) bus ();

    sargantana_itag_memory_flush #(
        .ICACHE_N_WAY   (NW),
        .TAG_DEPTH      (DEPTH),
        .TAG_ADDR_WIDHT (AW),
        .TAG_WIDHT      (TW)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs;
        bus.req_i     = '0;
        bus.we_i      = 1'b0;
        bus.vbit_i    = 1'b0;
        bus.flush_i   = 1'b0;
        bus.data_i    = '0;
        bus.addr_i    = '0;
        bus.cmp_tag_i = '0;
    endtask

    task automatic cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [NW-1:0] req, input logic [AW-1:0] addr,
                            input logic [TW-1:0] data, input logic v);
        bus.req_i  = req;
        bus.we_i   = 1'b1;
        bus.addr_i = addr;
        bus.data_i = data;
        bus.vbit_i = v;
        cycle();
        idle_inputs();
    endtask

    task automatic do_read(input logic [NW-1:0] req, input logic [AW-1:0] addr,
                           input logic [TW-1:0] cmp);
        bus.req_i     = req;
        bus.we_i      = 1'b0;
        bus.addr_i    = addr;
        bus.cmp_tag_i = cmp;
        cycle();
        idle_inputs();
    endtask

    // Counts sampled cycles with flush_busy_o high, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.flush_busy_o && n < 300) begin
            n++;
            cycle();
        end
    endtask

    task automatic test_reset;
        int n;
        rstn = 1'b0;
        idle_inputs();
        @(negedge clk);
        cycle();
        cycle();
        checks++;
        if (bus.vbit_o !== 4'b0000 || bus.tag_way_o !== '0 || bus.hit_o !== 1'b0 ||
            bus.parity_err_o !== 4'b0000 || bus.flush_busy_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: vbit=%b tag=%h hit=%b perr=%b busy=%b, want 0000/0/0/0000/1",
                     bus.vbit_o, bus.tag_way_o, bus.hit_o, bus.parity_err_o, bus.flush_busy_o);
        end
        rstn = 1'b1;
        count_busy(n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL reset_busy_len: got %0d cycles, want 64", n);
        end
        do_read(4'b1111, 6'd63, 20'h0);
        checks++;
        if (bus.vbit_o !== 4'b0000) begin
            errors++;
            $display("FAIL reset_set63_vbit: got %b, want 0000", bus.vbit_o);
        end
    endtask

    task automatic test_write_hit;
        do_write(4'b0100, 6'd5, 20'hABCDE, 1'b1);
        do_read(4'b1111, 6'd5, 20'hABCDE);
        checks++;
        if (bus.tag_way_o[2] !== 20'hABCDE || bus.vbit_o !== 4'b0100) begin
            errors++;
            $display("FAIL wr_rd_data: tag2=%h vbit=%b, want abcde/0100", bus.tag_way_o[2], bus.vbit_o);
        end
        checks++;
        if (bus.hit_way_o !== 4'b0100 || bus.hit_o !== 1'b1 || bus.multi_hit_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_rd_hit: hit_way=%b hit=%b multi=%b, want 0100/1/0",
                     bus.hit_way_o, bus.hit_o, bus.multi_hit_o);
        end
        do_read(4'b1111, 6'd5, 20'hABCDF);
        checks++;
        if (bus.hit_way_o !== 4'b0000 || bus.hit_o !== 1'b0) begin
            errors++;
            $display("FAIL tag_miss: hit_way=%b hit=%b, want 0000/0", bus.hit_way_o, bus.hit_o);
        end
        // A write leaves the outputs untouched.
        do_write(4'b0100, 6'd5, 20'h12121, 1'b0);
        checks++;
        if (bus.tag_way_o[2] !== 20'hABCDE || bus.vbit_o !== 4'b0100) begin
            errors++;
            $display("FAIL write_holds_out: tag2=%h vbit=%b, want abcde/0100", bus.tag_way_o[2], bus.vbit_o);
        end
        do_read(4'b0100, 6'd5, 20'h12121);
        checks++;
        if (bus.tag_way_o[2] !== 20'h12121 || bus.vbit_o !== 4'b0000 || bus.hit_o !== 1'b0) begin
            errors++;
            $display("FAIL invalid_entry: tag2=%h vbit=%b hit=%b, want 12121/0000/0",
                     bus.tag_way_o[2], bus.vbit_o, bus.hit_o);
        end
    endtask

    task automatic test_multi_hit;
        do_write(4'b1001, 6'd7, 20'h5A5A5, 1'b1);
        do_read(4'b1111, 6'd7, 20'h5A5A5);
        checks++;
        if (bus.hit_way_o !== 4'b1001 || bus.hit_o !== 1'b1 || bus.multi_hit_o !== 1'b1) begin
            errors++;
            $display("FAIL multi_hit: hit_way=%b hit=%b multi=%b, want 1001/1/1",
                     bus.hit_way_o, bus.hit_o, bus.multi_hit_o);
        end
        // Only way 0 re-read (set 5 way 0 is invalid); way 3 holds.
        do_read(4'b0001, 6'd5, 20'h5A5A5);
        checks++;
        if (bus.hit_way_o !== 4'b1000 || bus.multi_hit_o !== 1'b0 || bus.tag_way_o[3] !== 20'h5A5A5) begin
            errors++;
            $display("FAIL partial_read_hold: hit_way=%b multi=%b tag3=%h, want 1000/0/5a5a5",
                     bus.hit_way_o, bus.multi_hit_o, bus.tag_way_o[3]);
        end
    endtask

    task automatic test_flush_restart;
        int n;
        int bad;
        do_write(4'b0001, 6'd3, 20'h11111, 1'b1);
        do_read(4'b0001, 6'd3, 20'h11111);
        checks++;
        if (bus.vbit_o[0] !== 1'b1 || bus.tag_way_o[0] !== 20'h11111) begin
            errors++;
            $display("FAIL pre_flush_entry: vbit0=%b tag0=%h, want 1/11111", bus.vbit_o[0], bus.tag_way_o[0]);
        end
        // Flush together with a write: the write must be dropped.
        bus.flush_i = 1'b1;
        bus.we_i    = 1'b1;
        bus.req_i   = 4'b0001;
        bus.addr_i  = 6'd3;
        bus.data_i  = 20'h22222;
        bus.vbit_i  = 1'b1;
        cycle();
        idle_inputs();
        n = 0;
        while (bus.flush_busy_o && n < 300) begin
            n++;
            if (n == 30) bus.flush_i = 1'b1;
            cycle();
            bus.flush_i = 1'b0;
        end
        checks++;
        if (n !== 94) begin
            errors++;
            $display("FAIL flush_restart_len: got %0d cycles, want 94", n);
        end
        do_read(4'b0001, 6'd3, 20'h11111);
        checks++;
        if (bus.tag_way_o[0] !== 20'h11111 || bus.vbit_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_drops_write: tag0=%h vbit0=%b, want 11111/0", bus.tag_way_o[0], bus.vbit_o[0]);
        end
        bad = 0;
        for (int s = 0; s < 64; s++) begin
            do_read(4'b1111, AW'(s), 20'h0);
            if (bus.vbit_o !== 4'b0000) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL all_sets_invalid: %0d sets with valid bits, want 0", bad);
        end
    endtask

    task automatic test_reset_mid_flush;
        int n;
        bus.flush_i = 1'b1;
        cycle();
        bus.flush_i = 1'b0;
        for (int i = 0; i < 9; i++) cycle();
        rstn = 1'b0;
        cycle();
        rstn = 1'b1;
        count_busy(n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("FAIL reset_mid_flush_len: got %0d cycles, want 64", n);
        end
    endtask

    task automatic test_parity;
`ifdef ITAG_PARITY_EN
        do_write(4'b0011, 6'd9, 20'h0F0F0, 1'b1);
        dut.tag_mem[1][9][0] = ~dut.tag_mem[1][9][0];
        do_read(4'b1111, 6'd9, 20'h0F0F0);
        checks++;
        if (bus.parity_err_o !== 4'b0010 || bus.vbit_o !== 4'b0001 || bus.hit_way_o !== 4'b0001) begin
            errors++;
            $display("FAIL parity_detect: perr=%b vbit=%b hit_way=%b, want 0010/0001/0001",
                     bus.parity_err_o, bus.vbit_o, bus.hit_way_o);
        end
        do_read(4'b1111, 6'd10, 20'h0);
        checks++;
        if (bus.parity_err_o !== 4'b0000) begin
            errors++;
            $display("FAIL parity_clear: perr=%b, want 0000", bus.parity_err_o);
        end
`else
        do_write(4'b0010, 6'd9, 20'h0F0F1, 1'b1);
        do_read(4'b1111, 6'd9, 20'h0F0F1);
        checks++;
        if (bus.parity_err_o !== 4'b0000 || bus.hit_way_o !== 4'b0010) begin
            errors++;
            $display("FAIL no_parity: perr=%b hit_way=%b, want 0000/0010", bus.parity_err_o, bus.hit_way_o);
        end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_hit();
        test_multi_hit();
        test_flush_restart();
        test_reset_mid_flush();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sargantana_itag_memory_flush.md
Name: sargantana_itag_memory_flush

Overview:
- Parametrised next-generation L1 instruction-cache tag/valid store: ICACHE_N_WAY ways of TAG_DEPTH x TAG_WIDHT tags plus per-way valid bits.
- Adds a registered tag compare (per-way hit vector, multi-hit flag).
- Valid bits are held in a non-resettable array and cleared by a set-walking flush engine, run on reset and on flush_i.
- Sits between the icache controller (lookup/refill requests) and the icache data arrays.

Parameters:
- ICACHE_N_WAY, 4, number of ways (1..8).
- TAG_DEPTH, 64, sets per way (power of two, >=2).
- TAG_ADDR_WIDHT, $clog2(TAG_DEPTH), set index width.
- TAG_WIDHT, 20, tag bits per entry.

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  synchronous active-low reset.
- req_i  in  ICACHE_N_WAY  per-way access enable.
- we_i  in  1  1=write to ways selected by req_i, 0=read.
- vbit_i  in  1  valid bit to write.
- flush_i  in  1  start/restart invalidate-all.
- data_i  in  TAG_WIDHT  tag to write.
- addr_i  in  TAG_ADDR_WIDHT  set index.
- cmp_tag_i  in  TAG_WIDHT  lookup tag, sampled with a read.
- tag_way_o  out  ICACHE_N_WAY x TAG_WIDHT  registered tag per way.
- vbit_o  out  ICACHE_N_WAY  registered valid per way.
- hit_way_o  out  ICACHE_N_WAY  one bit per way: vbit_o[w] & (tag_way_o[w] == cmp_tag_q).
- hit_o  out  1  OR of hit_way_o.
- multi_hit_o  out  1  more than one hit_way_o bit set.
- flush_busy_o  out  1  flush engine active.
- parity_err_o  out  ICACHE_N_WAY  tag parity error per way (see Optional Feature).

Behaviour:
- FSM states: IDLE, FLUSH. Flush counter is TAG_ADDR_WIDHT wide.
- Reset (rstn_i=0 at a clock edge):
  - state<=FLUSH, counter<=0.
  - vbit_o, tag_way_o, cmp_tag_q, parity_err_o <= 0.
  - Tag and valid arrays are not reset.
- FLUSH:
  - Each cycle, clear valid[w][counter] for all w, then counter++.
  - When counter==TAG_DEPTH-1, clear that set and go to IDLE. A full flush takes exactly TAG_DEPTH cycles.
  - flush_busy_o = (state==FLUSH).
  - req_i is ignored: no write, outputs hold, vbit_o forced 0.
  - flush_i in FLUSH: counter<=0, the walk restarts.
- IDLE and flush_i=1: go to FLUSH with counter<=0. Any req_i in the same cycle is dropped (flush wins).
- IDLE write (we_i=1): for each w with req_i[w], tag[w][addr_i]<=data_i and valid[w][addr_i]<=vbit_i. Several ways may be written at once. Outputs hold their previous values.
- IDLE read (we_i=0, |req_i):
  - After 1 cycle: tag_way_o[w], vbit_o[w] <= array contents for each w with req_i[w]. Unselected ways hold.
  - cmp_tag_q <= cmp_tag_i.
  - Outputs hold until the next read.
- Read of a set written in the previous cycle returns the new contents.
- Hit logic is combinational from registered state only. hit_way_o is 0 for any way whose vbit_o is 0.
- Reset asserted mid-flush restarts the walk at set 0.
- addr_i wraps naturally; no out-of-range indices exist.

Optional Feature:
- Macro: ITAG_PARITY_EN.
- Defined:
  - Each tag entry stores an extra even-parity bit, computed from data_i on write.
  - On read, parity_err_o[w] is registered as the parity mismatch of way w, and vbit_o[w] is forced 0 for that way, so the way reads as a miss.
  - parity_err_o clears on the next read or on reset.
- Undefined:
  - No parity storage.
  - parity_err_o tied to 0.

Test Plan:
- Reset with TAG_DEPTH=64 -> flush_busy_o=1 for exactly 64 cycles, then 0; a read of set 63 in all ways returns vbit_o=4'b0000.
- Write data_i=20'hABCDE, vbit_i=1, req_i=4'b0100, addr_i=5; then read req_i=4'b1111, addr_i=5, cmp_tag_i=20'hABCDE -> next cycle tag_way_o[2]=20'hABCDE, hit_way_o=4'b0100, hit_o=1, multi_hit_o=0.
- Write the same tag to ways 0 and 3 of set 7 (req_i=4'b1001); read with a matching cmp_tag_i -> hit_way_o=4'b1001, multi_hit_o=1.
- In IDLE, drive flush_i=1 with a write req in the same cycle; at cycle 30 of the flush pulse flush_i again -> write dropped; busy lasts 30+64 cycles; all sets read invalid afterwards.
- Pulse rstn_i=0 at flush cycle 10 -> walk restarts, busy lasts 64 cycles after reset release.
- With ITAG_PARITY_EN, flip a stored tag bit of way 1 by backdoor and read -> parity_err_o=4'b0010, vbit_o[1]=0, hit_way_o[1]=0.
